register_unit: RTL and testbench

//  - RV32I integer register file (x0..x31) for the monocycle CPU; sits directly upstream of the ALU.
//  - Two combinational read ports drive the ALU operand path; RuRs1 -> A, RuRs2 -> B via the operand muxes.
//  - One synchronous write port is fed by the writeback mux (ALU S, load data or PC+4).
//  - x0 is hardwired to zero. x2 (sp) resets to a configurable stack top.

---
 rtl/register_unit.sv | 68 ++++++
 tb/tb_register_unit.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/register_unit.sv
// register_unit: RV32I integer register file (x0..x31).
// Two combinational read ports, one synchronous write port, x0 hardwired to 0,
// x2 (sp) resets to SP_INIT. Synchronous active-high reset clears the whole
// array in one cycle.
// Optional feature macro: RU_WRITE_BYPASS_EN. When it is defined, a write to
// the address being read is forwarded to the read port in the same cycle.
// Without it, reads show the contents from before the edge, which is the mode
// the monocycle CPU needs.
module register_unit #(
  parameter int              XLEN    = 32,
  parameter int              NREGS   = 32,
  parameter logic [XLEN-1:0] SP_INIT = 32'h0000_03FC,
  localparam int             AW      = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   Rs1,
  input  logic [AW-1:0]   Rs2,
  input  logic [AW-1:0]   Rd,
  input  logic            RuWr,
  input  logic [XLEN-1:0] DataWr,
  output logic [XLEN-1:0] RuRs1,
  output logic [XLEN-1:0] RuRs2
);

  // Address bound, widened by one bit so that NREGS == 2**AW still fits.
  localparam logic [AW:0] NREGS_W = NREGS[AW:0];

  logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
  logic                       wr_en;

  // A write counts only for an in-range, non-zero destination.
  assign wr_en = RuWr && (Rd != '0) && ({1'b0, Rd} < NREGS_W);

  // Next-state array: a single write port, and entry 0 is pinned to zero.
  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[Rd] = DataWr;
    regs_d[0] = '0;
  end

  // State update. Reset takes priority over a pending write, which is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++)
        regs_q[i] <= (i == 2) ? SP_INIT : '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read port 1. Address 0 always reads zero, even when a bypass is possible.
  always_comb begin
    RuRs1 = (Rs1 == '0) ? '0 : regs_q[Rs1];
`ifdef RU_WRITE_BYPASS_EN
    if (!rst && wr_en && (Rd == Rs1)) RuRs1 = DataWr;
`endif
  end

  // Read port 2, independent of port 1.
  always_comb begin
    RuRs2 = (Rs2 == '0) ? '0 : regs_q[Rs2];
`ifdef RU_WRITE_BYPASS_EN
    if (!rst && wr_en && (Rd == Rs2)) RuRs2 = DataWr;
`endif
  end

endmodule

// File: tb/tb_register_unit.sv
// tb_register_unit: directed scoreboard bench for register_unit.
// Stimulus pushes the expected read-port values into a queue. A monitor on the
// falling edge pops and compares them against the combinational outputs.
module tb_register_unit;

  localparam logic [31:0] SP = 32'h0000_03FC;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  Rs1, Rs2, Rd;
  logic        RuWr;
  logic [31:0] DataWr;
  logic [31:0] RuRs1, RuRs2;

  typedef struct {
    string       name;
    logic [31:0] e1;
    logic [31:0] e2;
    bit          chk2;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  register_unit dut (
    .clk   (clk),
    .rst   (rst),
    .Rs1   (Rs1),
    .Rs2   (Rs2),
    .Rd    (Rd),
    .RuWr  (RuWr),
    .DataWr(DataWr),
    .RuRs1 (RuRs1),
    .RuRs2 (RuRs2)
  );

  always #5 clk = ~clk;

  // Monitor: compare the outputs mid-cycle against any expectation queued this cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_tests++;
      if (RuRs1 !== e.e1) begin
        n_fail++;
        $display("FAIL %s RuRs1: got %h expected %h", e.name, RuRs1, e.e1);
      end
      if (e.chk2) begin
        n_tests++;
        if (RuRs2 !== e.e2) begin
          n_fail++;
          $display("FAIL %s RuRs2: got %h expected %h", e.name, RuRs2, e.e2);
        end
      end
    end
  end

  // Drive one cycle of inputs just after the rising edge. A non-empty name
  // queues an expectation for the reads in this same cycle.
  task automatic step(input logic r, input logic we, input logic [4:0] rd,
                      input logic [31:0] wd, input logic [4:0] a1,
                      input logic [4:0] a2, input string name,
                      input logic [31:0] e1, input logic [31:0] e2,
                      input bit chk2);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; RuWr = we; Rd = rd; DataWr = wd; Rs1 = a1; Rs2 = a2;
    if (name != "") begin
      e.name = name; e.e1 = e1; e.e2 = e2; e.chk2 = chk2;
      exp_q.push_back(e);
    end
  endtask

  // Expected RuRs1 when x7 is read while 32'h22 is being written to it.
  logic [31:0] same_cycle_exp;
  logic [31:0] alu_s;

  initial begin
`ifdef RU_WRITE_BYPASS_EN
    same_cycle_exp = 32'h22;
`else
    same_cycle_exp = 32'h1;
`endif
    rst = 1'b1; RuWr = 1'b0; Rd = '0; DataWr = '0; Rs1 = '0; Rs2 = '0;

    // Reset for one cycle, then sweep every address on both ports.
    step(1, 0, 0, 0, 0, 0, "", 0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      logic [4:0]  a1, a2;
      logic [31:0] v1, v2;
      a1 = 5'(i); a2 = 5'(31 - i);
      v1 = (i == 2) ? SP : 32'h0;
      v2 = ((31 - i) == 2) ? SP : 32'h0;
      step(0, 0, 0, 0, a1, a2, "reset_sweep", v1, v2, 1);
    end

    // Write x5, then read it on both ports.
    step(0, 1, 5, 32'hDEAD_BEEF, 0, 0, "wr_x5_rd0", 0, 0, 1);
    step(0, 0, 0, 0, 5, 5, "rd_x5", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1);

    // x0 protection, including the cycle of the write attempt.
    step(0, 1, 0, 32'hFFFF_FFFF, 0, 0, "x0_wr_cycle", 0, 0, 1);
    step(0, 0, 0, 0, 0, 5, "x0_after", 0, 32'hDEAD_BEEF, 1);

    // Read and write the same address in one cycle.
    step(0, 1, 7, 32'h1, 0, 0, "", 0, 0, 0);
    step(0, 1, 7, 32'h22, 7, 5, "same_cycle_rw", same_cycle_exp, 32'hDEAD_BEEF, 1);
    step(0, 0, 0, 0, 7, 0, "after_rw", 32'h22, 0, 1);

    // Top address.
    step(0, 1, 31, 32'hA5A5_5A5A, 0, 0, "", 0, 0, 0);
    step(0, 0, 0, 0, 31, 30, "x31", 32'hA5A5_5A5A, 0, 1);

    // Reset priority over a write issued in the reset cycle.
    step(0, 1, 9, 32'h55, 0, 0, "", 0, 0, 0);
    step(0, 0, 0, 0, 9, 0, "x9_pre", 32'h55, 0, 1);
    step(1, 1, 9, 32'hAA, 9, 2, "rst_cycle", 32'h55, SP, 1);
    step(0, 0, 0, 0, 9, 5, "rst_prio", 0, 0, 1);
    step(0, 0, 0, 0, 2, 31, "rst_mid_sp", SP, 0, 1);

    // ALU hookup: x1=5, x3=3, sub -> 2 written back to x4.
    step(0, 1, 1, 32'd5, 0, 0, "", 0, 0, 0);
    step(0, 1, 3, 32'd3, 0, 0, "", 0, 0, 0);
    step(0, 0, 0, 0, 1, 3, "alu_ops", 32'd5, 32'd3, 1);
    alu_s = 32'd5 - 32'd3;
    step(0, 1, 4, alu_s, 0, 0, "", 0, 0, 0);
    step(0, 0, 0, 0, 4, 2, "alu_wb", 32'd2, SP, 1);

    // RuWr=0 holds the array whatever Rd/DataWr are.
    step(0, 0, 4, 'x, 4, 4, "hold_x", 32'd2, 32'd2, 1);
    step(0, 0, 4, 32'h1234_5678, 4, 1, "hold_after", 32'd2, 32'd5, 1);

    @(posedge clk);
    @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
